branch_address: RTL and testbench

//   Branch-offset generator for the single-cycle MIPS datapath.
//   - Sign-extends the 16-bit I-type immediate and shifts it left by 2 to form the word-aligned byte offset.
//   - Adds the offset to PC+4 to form the branch target.
//   - Also provides a registered copy of the target for the pipelined/fetch path.

---
 rtl/branch_address.sv | 77 +++++++
 tb/tb_branch_address.sv | 125 ++++++++++++
 2 files changed

// File: rtl/branch_address.sv
// -----------------------------------------------------------------------------
// branch_address
//   Branch-offset generator for the single-cycle MIPS datapath.
//   The 16-bit I-type immediate is a signed word offset. It is sign-extended
//   and shifted left by SHIFT to form a byte offset. That offset is added to
//   PC+4 to give the branch target. A registered copy of the target is also
//   provided for the fetch path.
//
// Ports
//   clk           in   1           clock; only target_addr_q uses it
//   reset         in   1           synchronous, active-high; clears target_addr_q
//   immediate     in   IMM_WIDTH   instruction[15:0], two's-complement word offset
//   pc_plus4      in   ADDR_WIDTH  address of the instruction after the branch
//   load_en       in   1           capture target_addr on the next clk rise
//   branch_addr   out  ADDR_WIDTH  sign-extended immediate << SHIFT (combinational)
//   target_addr   out  ADDR_WIDTH  pc_plus4 + branch_addr, wraps silently (comb.)
//   target_addr_q out  ADDR_WIDTH  registered target_addr
//   offset_neg    out  1           sign of the offset (immediate MSB)
// -----------------------------------------------------------------------------
module branch_address #(
  parameter int IMM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int SHIFT      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IMM_WIDTH-1:0]  immediate,
  input  logic [ADDR_WIDTH-1:0] pc_plus4,
  input  logic                  load_en,
  output logic [ADDR_WIDTH-1:0] branch_addr,
  output logic [ADDR_WIDTH-1:0] target_addr,
  output logic [ADDR_WIDTH-1:0] target_addr_q,
  output logic                  offset_neg
);

  // Sign-extend a word offset to the address width, then scale it to bytes.
  // The arithmetic shift fills the low SHIFT bits with zeros, so the result
  // is always word aligned.
  function automatic logic signed [ADDR_WIDTH-1:0] sext_scale(
    input logic signed [IMM_WIDTH-1:0] imm
  );
    logic signed [ADDR_WIDTH-1:0] ext;
    ext = ADDR_WIDTH'(imm);
    return ext <<< SHIFT;
  endfunction

  logic signed [IMM_WIDTH-1:0]  imm_s;
  logic signed [ADDR_WIDTH-1:0] offset_s;
  logic        [ADDR_WIDTH-1:0] target_addr_d;

  always_comb begin
    imm_s       = signed'(immediate);
    offset_s    = sext_scale(imm_s);
    branch_addr = offset_s;
    offset_neg  = immediate[IMM_WIDTH-1];
    // Modulo 2^ADDR_WIDTH add. The carry is dropped on purpose, because
    // branch targets wrap around the address space.
    target_addr = pc_plus4 + branch_addr;
  end

  always_comb begin
    target_addr_d = target_addr_q;
    if (load_en) begin
      target_addr_d = target_addr;
    end
  end

  // ---- register stage: target capture for the fetch path ----
  always_ff @(posedge clk) begin
    if (reset) begin
      target_addr_q <= '0;
    end else begin
      target_addr_q <= target_addr_d;
    end
  end

endmodule

// File: tb/tb_branch_address.sv
module tb_branch_address;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] immediate;
  logic [31:0] pc_plus4;
  logic        load_en;
  logic [31:0] branch_addr;
  logic [31:0] target_addr;
  logic [31:0] target_addr_q;
  logic        offset_neg;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: the expected registered target.
  logic [31:0] exp_q;

  always #5 clk = ~clk;

  branch_address dut (
    .clk          (clk),
    .reset        (reset),
    .immediate    (immediate),
    .pc_plus4     (pc_plus4),
    .load_en      (load_en),
    .branch_addr  (branch_addr),
    .target_addr  (target_addr),
    .target_addr_q(target_addr_q),
    .offset_neg   (offset_neg)
  );

  // Behavioural reference: signed integer arithmetic, truncated to 32 bits.
  function automatic logic [31:0] m_branch(input logic [15:0] imm);
    longint off;
    off = longint'($signed(imm)) * 4;
    return off[31:0];
  endfunction

  function automatic logic [31:0] m_target(input logic [15:0] imm,
                                           input logic [31:0] pc);
    longint t;
    t = longint'(pc) + longint'($signed(imm)) * 4;
    return t[31:0];
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one vector, check the combinational outputs, clock it, and then
  // check the register against the model.
  task automatic step(input logic [15:0] imm, input logic [31:0] pc,
                      input logic ld, input logic rst, input string tag);
    immediate = imm;
    pc_plus4  = pc;
    load_en   = ld;
    reset     = rst;
    #1;
    check32({tag, ".branch"}, branch_addr, m_branch(imm));
    check32({tag, ".target"}, target_addr, m_target(imm, pc));
    check32({tag, ".neg"},    {31'd0, offset_neg},
            {31'd0, (longint'($signed(imm)) < 0) ? 1'b1 : 1'b0});
    @(posedge clk);
    if (rst)     exp_q = 32'h0;
    else if (ld) exp_q = m_target(imm, pc);
    #1;
    check32({tag, ".q"}, target_addr_q, exp_q);
  endtask

  initial begin
    reset     = 1'b1;
    load_en   = 1'b0;
    immediate = 16'h0;
    pc_plus4  = 32'h0;
    exp_q     = 32'h0;
    @(posedge clk);
    #1;
    check32("reset_q", target_addr_q, 32'h0);

    // The combinational path must respond with no clock edge.
    reset     = 1'b0;
    immediate = 16'h7FFF;
    #1;
    check32("imm7fff_branch", branch_addr, 32'h0001_FFFC);
    immediate = 16'h8000;
    #1;
    check32("imm8000_branch", branch_addr, 32'hFFFE_0000);
    check32("imm8000_neg", {31'd0, offset_neg}, 32'd1);
    immediate = 16'hFFFF;
    pc_plus4  = 32'h0000_0004;
    #1;
    check32("immffff_branch", branch_addr, 32'hFFFF_FFFC);
    check32("immffff_target", target_addr, 32'h0000_0000);
    immediate = 16'h0001;
    pc_plus4  = 32'hFFFF_FFFC;
    #1;
    check32("wrap_target", target_addr, 32'h0000_0000);

    @(posedge clk);
    #1;
    step(16'h0010, 32'h0040_0000, 1'b1, 1'b0, "load");
    check32("load_abs", target_addr_q, 32'h0040_0040);
    step(16'h1234, 32'h1000_0000, 1'b0, 1'b0, "hold");
    check32("hold_abs", target_addr_q, 32'h0040_0040);
    step(16'h8001, 32'h0000_1000, 1'b1, 1'b1, "rst_pri");
    check32("rst_pri_abs", target_addr_q, 32'h0);
    step(16'h0003, 32'h0000_0100, 1'b1, 1'b0, "reload");

    for (int i = 0; i < 200; i++) begin
      step(16'($urandom), 32'($urandom),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
